// File: rtl/slot_fifo_scheduler.sv
// Round-robin burst drain of NUM_SLOTS pointer-tracked FIFOs into one byte stream.
// Define SLOT_SCHED_FULL_FLAG_EN to build the sticky per-slot full flags.
module slot_fifo_scheduler #(
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned BURST_LEN   = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_SLOTS-1:0]             slot_enable,
  input  logic                             flush,
  input  logic [NUM_SLOTS*ADDR_WIDTH-1:0]  fifo_addr_in,
  input  logic [NUM_SLOTS*ADDR_WIDTH-1:0]  fifo_addr_out,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0]  fifo_data,
  output logic [NUM_SLOTS-1:0]             fifo_read,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(NUM_SLOTS)-1:0]     out_slot,
  output logic                             out_last,
  input  logic [NUM_SLOTS-1:0]             counter_clear,
  output logic [NUM_SLOTS*COUNT_WIDTH-1:0] byte_counts,
  output logic [NUM_SLOTS-1:0]             fifo_full_flag
);

  localparam int unsigned SlotW = $clog2(NUM_SLOTS);
  localparam int unsigned RemW  = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_WIDTH-1:0] BurstThr = ADDR_WIDTH'(BURST_LEN);
  localparam logic [RemW-1:0]       BurstRem = RemW'(BURST_LEN);

  typedef enum logic [2:0] {StIdle, StArb, StRd, StCap, StXfer} state_e;

  state_e                 r_state, w_state_d;
  logic [SlotW-1:0]       r_slot, r_last_served, w_pick, w_scan;
  logic [RemW-1:0]        r_remaining, w_burst;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic                   r_out_valid, r_out_last, w_found, w_accept;
  logic [ADDR_WIDTH-1:0]  w_level [NUM_SLOTS];
  logic [DATA_WIDTH-1:0]  w_data [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   w_eligible;
  logic [COUNT_WIDTH-1:0] r_counts [NUM_SLOTS];

  // Modular pointer difference gives the fill level across wrap.
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    assign w_level[s] = fifo_addr_in[s*ADDR_WIDTH +: ADDR_WIDTH] -
                        fifo_addr_out[s*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data[s] = fifo_data[s*DATA_WIDTH +: DATA_WIDTH];
    assign w_eligible[s] = slot_enable[s] &
                           (flush ? (w_level[s] != '0) : (w_level[s] >= BurstThr));
    assign byte_counts[s*COUNT_WIDTH +: COUNT_WIDTH] = r_counts[s];
    assign fifo_read[s] = (r_state == StRd) && (r_slot == SlotW'(s));
  end

  // Scan starts one past the last served slot and wraps.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_scan  = r_last_served;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      w_scan = (w_scan == SlotW'(NUM_SLOTS - 1)) ? '0 : w_scan + 1'b1;
      if (!w_found && w_eligible[w_scan]) begin
        w_found = 1'b1;
        w_pick  = w_scan;
      end
    end
    w_burst = (w_level[w_pick] >= BurstThr) ? BurstRem : RemW'(w_level[w_pick]);
  end

  always_comb begin
    w_state_d = r_state;
    w_accept  = (r_state == StXfer) && out_ready;
    case (r_state)
      StIdle:  if (|w_eligible) w_state_d = StArb;
      StArb:   w_state_d = w_found ? StRd : StIdle;
      StRd:    w_state_d = StCap;
      StCap:   w_state_d = StXfer;
      StXfer:  if (out_ready) w_state_d = (r_remaining > RemW'(1)) ? StRd : StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_slot        <= '0;
      r_last_served <= SlotW'(NUM_SLOTS - 1);
      r_remaining   <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StArb && w_found) begin
        r_slot      <= w_pick;
        r_remaining <= w_burst;
      end
      if (r_state == StCap) begin
        r_out_data  <= w_data[r_slot];
        r_out_valid <= 1'b1;
        r_out_last  <= (r_remaining == RemW'(1));
      end
      if (w_accept) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_remaining <= r_remaining - 1'b1;
        if (r_remaining == RemW'(1)) r_last_served <= r_slot;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (reset || counter_clear[s]) begin
        r_counts[s] <= '0;
      end else if (w_accept && (r_slot == SlotW'(s))) begin
        r_counts[s] <= r_counts[s] + 1'b1;
      end
    end
  end

`ifdef SLOT_SCHED_FULL_FLAG_EN
  logic [NUM_SLOTS-1:0] r_full;

  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (reset || counter_clear[s]) begin
        r_full[s] <= 1'b0;
      end else if (&w_level[s]) begin
        r_full[s] <= 1'b1;
      end
    end
  end

  assign fifo_full_flag = r_full;
`else
  assign fifo_full_flag = '0;
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_slot  = r_slot;

endmodule

// File: tb/tb_slot_fifo_scheduler.sv
// Bench for slot_fifo_scheduler: FIFO model, burst-plan reference, table vectors and random runs.
module tb_slot_fifo_scheduler;
  localparam int NS    = 4;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int CW    = 32;
  localparam int DEPTH = 2048;

  logic               clk = 1'b0;
  logic               reset;
  logic [NS-1:0]      slot_enable;
  logic               flush;
  logic [NS*AW-1:0]   fifo_addr_in, fifo_addr_out;
  logic [NS*DW-1:0]   fifo_data;
  logic [NS-1:0]      fifo_read;
  logic [DW-1:0]      out_data;
  logic               out_valid, out_ready, out_last;
  logic [1:0]         out_slot;
  logic [NS-1:0]      counter_clear;
  logic [NS*CW-1:0]   byte_counts;
  logic [NS-1:0]      fifo_full_flag;

  slot_fifo_scheduler dut (
    .clk(clk), .reset(reset), .slot_enable(slot_enable), .flush(flush),
    .fifo_addr_in(fifo_addr_in), .fifo_addr_out(fifo_addr_out), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_slot(out_slot), .out_last(out_last), .counter_clear(counter_clear),
    .byte_counts(byte_counts), .fifo_full_flag(fifo_full_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [1:0] slot; logic last; logic [7:0] data;} word_t;
  typedef struct packed {
    logic [3:0][7:0] lvl; logic [10:0] base; logic [3:0] en; logic fl; logic [3:0][7:0] ex;
  } vec_t;

  int        wr_ptr[NS], rd_ptr[NS];
  logic [7:0] fdata[NS];
  word_t     exp_q[$];
  int        n_tests = 0, n_fail = 0;
  int        m_last = NS - 1;
  int        m_cnt[NS], m_fin[NS];
  bit        rand_rdy = 1'b0;
  vec_t      vecs[8];

  always_comb begin
    fifo_addr_in = '0; fifo_addr_out = '0; fifo_data = '0;
    for (int s = 0; s < NS; s++) begin
      fifo_addr_in[s*AW +: AW]  = AW'(wr_ptr[s]);
      fifo_addr_out[s*AW +: AW] = AW'(rd_ptr[s]);
      fifo_data[s*DW +: DW]     = fdata[s];
    end
  end

  function automatic logic [7:0] wval(int s, int a);
    return 8'(s * 53 + a * 7 + 1);
  endfunction

  function automatic logic [31:0] cnt(int s);
    return byte_counts[s*CW +: CW];
  endfunction

  function automatic vec_t mk(int l0, int l1, int l2, int l3, int base, logic [3:0] en,
                              logic fl, int e0, int e1, int e2, int e3);
    vec_t v;
    v.lvl[0] = 8'(l0); v.lvl[1] = 8'(l1); v.lvl[2] = 8'(l2); v.lvl[3] = 8'(l3);
    v.base = 11'(base); v.en = en; v.fl = fl;
    v.ex[0] = 8'(e0); v.ex[1] = 8'(e1); v.ex[2] = 8'(e2); v.ex[3] = 8'(e3);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // One clock: observe at negedge, then apply FIFO read side effects just after posedge.
  task automatic tick();
    word_t e;
    logic [3:0] rd;
    @(negedge clk);
    rd = fifo_read;
    check("read_excl", {63'd0, ((out_valid && rd != 0) || !$onehot0(rd))}, 64'd0);
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_word", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("word", {53'd0, out_slot, out_last, out_data}, {53'd0, e});
      end
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (rd[s]) begin
        fdata[s]  = wval(s, rd_ptr[s]);
        rd_ptr[s] = (rd_ptr[s] + 1) % DEPTH;
      end
    end
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic set_slot(input int s, input int base, input int lv);
    rd_ptr[s] = base % DEPTH;
    wr_ptr[s] = (base + lv) % DEPTH;
  endtask

  // Reference: whole bursts chosen round-robin from the slot after the last one served.
  task automatic plan();
    int lv[NS];
    int p[NS];
    int k, n, c;
    bit go;
    word_t w;
    for (int s = 0; s < NS; s++) begin
      lv[s] = (wr_ptr[s] - rd_ptr[s] + DEPTH) % DEPTH;
      p[s]  = rd_ptr[s];
    end
    go = 1'b1;
    while (go) begin
      k = -1;
      for (int i = 1; i <= NS; i++) begin
        c = (m_last + i) % NS;
        if (k < 0 && slot_enable[c] && (flush ? lv[c] >= 1 : lv[c] >= 16)) k = c;
      end
      if (k < 0) go = 1'b0;
      else begin
        n = (lv[k] < 16) ? lv[k] : 16;
        for (int j = 0; j < n; j++) begin
          w.slot = 2'(k); w.last = (j == n - 1); w.data = wval(k, (p[k] + j) % DEPTH);
          exp_q.push_back(w);
        end
        p[k] = (p[k] + n) % DEPTH; lv[k] -= n; m_cnt[k] += n; m_last = k;
      end
    end
    for (int s = 0; s < NS; s++) m_fin[s] = p[s];
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
  endtask

  task automatic check_reads(input string tag);
    for (int s = 0; s < NS; s++) check($sformatf("%s_rdptr%0d", tag, s), 64'(rd_ptr[s]), 64'(m_fin[s]));
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check(tag, {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv;
    logic [7:0] d;
    logic [31:0] c;
    int lv;

    vecs[0] = mk(0, 0, 16, 0, 10, 4'b0100, 1'b0, 0, 0, 16, 0);
    vecs[1] = mk(32, 32, 0, 0, 200, 4'b1111, 1'b0, 32, 32, 0, 0);
    vecs[2] = mk(0, 0, 0, 11, 2040, 4'b1000, 1'b0, 0, 0, 0, 0);
    vecs[3] = mk(0, 0, 0, 11, 2040, 4'b1000, 1'b1, 0, 0, 0, 11);
    vecs[4] = mk(20, 5, 16, 3, 1000, 4'b1111, 1'b0, 16, 0, 16, 0);
    vecs[5] = mk(20, 5, 16, 3, 2030, 4'b1111, 1'b1, 20, 5, 16, 3);
    vecs[6] = mk(30, 30, 30, 30, 5, 4'b0000, 1'b1, 0, 0, 0, 0);
    vecs[7] = mk(16, 40, 16, 40, 1500, 4'b0101, 1'b0, 16, 0, 16, 0);

    reset = 1'b1; slot_enable = '0; flush = 1'b0; out_ready = 1'b0; counter_clear = '0;
    for (int s = 0; s < NS; s++) begin
      wr_ptr[s] = 0; rd_ptr[s] = 0; fdata[s] = '0; m_cnt[s] = 0; m_fin[s] = 0;
    end
    repeat (3) tick();
    reset = 1'b0;
    check("rst_read", 64'(fifo_read), 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_slot", 64'(out_slot), 64'd0);
    check("rst_last", {63'd0, out_last}, 64'd0);
    check("rst_flag", 64'(fifo_full_flag), 64'd0);
    for (int s = 0; s < NS; s++) check($sformatf("rst_cnt%0d", s), 64'(cnt(s)), 64'd0);

    for (int v = 0; v < 8; v++) begin
      tv = vecs[v];
      out_ready = 1'b1; slot_enable = tv.en; flush = tv.fl; counter_clear = '1;
      for (int s = 0; s < NS; s++) begin
        set_slot(s, int'(tv.base), int'(tv.lvl[s]));
        m_cnt[s] = 0;
      end
      plan();
      tick();
      counter_clear = '0;
      drain(2000);
      for (int s = 0; s < NS; s++)
        check($sformatf("vec%0d_cnt%0d", v, s), 64'(cnt(s)), 64'(tv.ex[s]));
      check_reads($sformatf("vec%0d", v));
    end

    // Latency from idle, then a 10-cycle stall mid-burst.
    for (int s = 0; s < NS; s++) set_slot(s, 0, 0);
    set_slot(1, 100, 16); slot_enable = 4'b0010; flush = 1'b0; out_ready = 1'b0;
    plan();
    tick(); tick();
    check("lat_read", 64'(fifo_read), 64'b0010);
    tick();
    check("lat_cap", {63'd0, out_valid}, 64'd0);
    tick();
    check("lat_valid", {63'd0, out_valid}, 64'd1);
    d = out_data; c = cnt(1);
    repeat (10) begin
      tick();
      check("hold_data", 64'(out_data), 64'(d));
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_read", 64'(fifo_read), 64'd0);
      check("hold_cnt", 64'(cnt(1)), 64'(c));
    end
    out_ready = 1'b1;
    drain(500);
    check("hold_total", 64'(cnt(1)), 64'(c + 16));
    check_reads("hold");

    // Clear in the same cycle as an accept on slot 1.
    for (int s = 0; s < NS; s++) set_slot(s, 0, 0);
    set_slot(1, 300, 16); out_ready = 1'b0;
    plan();
    wait_valid("clr_wait");
    out_ready = 1'b1; counter_clear = 4'b0010;
    tick();
    counter_clear = '0; out_ready = 1'b0;
    check("clr_vs_accept", 64'(cnt(1)), 64'd0);
    out_ready = 1'b1;
    drain(500);
    check("clr_after", 64'(cnt(1)), 64'd15);
    check_reads("clr");

    // Reset while a word is waiting for acceptance.
    for (int s = 0; s < NS; s++) set_slot(s, 0, 0);
    set_slot(0, 500, 16); slot_enable = 4'b0001; out_ready = 1'b0;
    plan();
    wait_valid("rstx_wait");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstx_valid", {63'd0, out_valid}, 64'd0);
    check("rstx_read", 64'(fifo_read), 64'd0);
    check("rstx_last", {63'd0, out_last}, 64'd0);
    for (int s = 0; s < NS; s++) check($sformatf("rstx_cnt%0d", s), 64'(cnt(s)), 64'd0);
    check("rstx_drop", 64'(rd_ptr[0]), 64'd501);
    exp_q.delete();
    m_last = NS - 1;
    slot_enable = '0;
    for (int s = 0; s < NS; s++) set_slot(s, 0, 0);
    repeat (5) tick();

    // Full flag at level 2**ADDR_WIDTH-1.
    set_slot(1, 0, DEPTH - 1);
    repeat (2) tick();
`ifdef SLOT_SCHED_FULL_FLAG_EN
    check("flag_set", 64'(fifo_full_flag), 64'b0010);
    counter_clear = 4'b0010;
    tick();
    counter_clear = '0;
    check("flag_clear_wins", 64'(fifo_full_flag), 64'd0);
    tick();
    check("flag_reset", 64'(fifo_full_flag), 64'b0010);
    set_slot(1, 0, 0);
    repeat (3) tick();
    check("flag_sticky", 64'(fifo_full_flag), 64'b0010);
    counter_clear = 4'b0010;
    tick();
    counter_clear = '0;
    check("flag_cleared", 64'(fifo_full_flag), 64'd0);
`else
    check("flag_off", 64'(fifo_full_flag), 64'd0);
    set_slot(1, 0, 0);
    tick();
`endif

    for (int it = 0; it < 25; it++) begin
      counter_clear = '1;
      slot_enable = 4'($urandom);
      flush = 1'($urandom);
      out_ready = 1'b1;
      for (int s = 0; s < NS; s++) begin
        lv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
        set_slot(s, int'($urandom_range(0, DEPTH - 1)), lv);
        m_cnt[s] = 0;
      end
      plan();
      rand_rdy = 1'b1;
      tick();
      counter_clear = '0;
      drain(6000);
      for (int s = 0; s < NS; s++)
        check($sformatf("rnd%0d_cnt%0d", it, s), 64'(cnt(s)), 64'(m_cnt[s]));
      check_reads($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
